axil_lb_bridge: RTL and testbench
=================================

Name: axil_lb_bridge

Overview:
- AXI4-Lite slave to simple local-bus (LB) master bridge, one clock domain.
- Converts each AXI-Lite write or read into a single LB write or read.
- Sits between the system AXI-Lite interconnect and a register block (CSR map).
- Write and read paths are independent FSMs and may run concurrently.

Parameters:
- ADDR_W, 16, byte address width on both AXI-Lite and LB.
- DATA_W, 32, data width; a multiple of 8.
- STRB_W, DATA_W/8, byte-strobe width.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- AXIL_AWADDR  in  ADDR_W  write address.
- AXIL_AWPROT  in  3  ignored.
- AXIL_AWVALID  in  1 / AXIL_AWREADY  out  1  write-address handshake.
- AXIL_WDATA  in  DATA_W  write data.
- AXIL_WSTRB  in  STRB_W  write strobes.
- AXIL_WVALID  in  1 / AXIL_WREADY  out  1  write-data handshake.
- AXIL_BRESP  out  2  always 2'b00 (OKAY).
- AXIL_BVALID  out  1 / AXIL_BREADY  in  1  write-response handshake.
- AXIL_ARADDR  in  ADDR_W  read address.
- AXIL_ARPROT  in  3  ignored.
- AXIL_ARVALID  in  1 / AXIL_ARREADY  out  1  read-address handshake.
- AXIL_RDATA  out  DATA_W  read data.
- AXIL_RRESP  out  2  always 2'b00.
- AXIL_RVALID  out  1 / AXIL_RREADY  in  1  read-data handshake.
- wready  in  1  LB slave accepts the write this cycle.
- waddr  out  ADDR_W / wdata  out  DATA_W / wstrb  out  STRB_W  LB write request fields.
- wen  out  1  LB write request.
- rdata  in  DATA_W / rvalid  in  1  LB read return.
- raddr  out  ADDR_W  LB read address.
- ren  out  1  LB read strobe.

Behaviour:
- Reset values: all outputs 0, including AWREADY, WREADY, ARREADY, BVALID, RVALID, wen, ren, waddr, wdata, wstrb, raddr, AXIL_RDATA. Both FSMs return to IDLE.
- Write FSM states: W_IDLE, W_LB, W_RESP.
- W_IDLE, address channel:
  - AWREADY = 1 while AW is not yet captured.
  - On AWVALID & AWREADY, latch AWADDR into waddr and set aw_got.
- W_IDLE, data channel:
  - WREADY = 1 while W is not yet captured.
  - On WVALID & WREADY, latch WDATA into wdata and WSTRB into wstrb, and set w_got.
- AW and W may arrive in either order or in the same cycle.
- When both are captured (including a same-cycle capture of the second one), go to W_LB on the next edge. wen = 1 from the cycle after the last handshake.
- W_LB: hold wen = 1 until wready = 1 is sampled at a rising edge, for any number of wait cycles. Then wen drops, go to W_RESP, and clear aw_got and w_got.
- W_RESP: BVALID = 1, BRESP = 00. On BREADY, go to W_IDLE.
- waddr, wdata and wstrb stay stable after the LB write completes, until the next AW or W capture.
- Read FSM states: R_IDLE, R_REQ, R_WAIT, R_RESP.
- R_IDLE: ARREADY = 1. On ARVALID, latch ARADDR into raddr and go to R_REQ.
- R_REQ: ren = 1 for exactly one cycle, then go to R_WAIT.
  - If rvalid is high in R_REQ, capture rdata and go directly to R_RESP.
- R_WAIT: wait any number of cycles for rvalid. On rvalid, capture rdata into AXIL_RDATA and go to R_RESP.
- R_RESP: RVALID = 1, RRESP = 00, RDATA stable. On RREADY, go to R_IDLE.
- raddr holds until the next AR capture.
- rvalid outside R_REQ/R_WAIT is ignored.
- AXI handshake rules:
  - VALID outputs never drop without the matching READY.
  - Only one outstanding write and one outstanding read at a time.
  - AWREADY, WREADY and ARREADY are 0 outside IDLE.
- Reset mid-transaction aborts it immediately. No response is issued and no LB strobe follows.

Decomposition:
- Shared package axil_lb_pkg: FSM state enums, and RESP_OKAY = 2'b00.
- Sub-modules: none; the write and read FSMs stay in one module as separate always blocks.

Test Plan:
- Simple write: AW = 0x004 and W = 0xdeadbeef with strb 0xF concurrently.
  - wen asserts once; sampled with wready = 1, waddr = 0x004, wdata = 0xdeadbeef, wstrb = 4'b1111.
  - BVALID then asserts with BRESP = 00.
- Strobed write: 0x00c / 0xcafebabe, strb 4'b0110 → wstrb = 4'b0110, other fields matching.
- Write wait states: wready held 0 for 5 cycles, write 0x010 / 0x0acce55.
  - wen stays high throughout; completes once wready rises.
  - BVALID only appears after completion; fields stay correct.
- Read, 1 wait cycle: AR = 0x014; ren pulses one cycle with raddr = 0x014.
  - LB returns 0xc0debabe with rvalid one cycle later → RDATA = 0xc0debabe, RRESP = 00.
- Read, 5 wait cycles: AR = 0x008, rvalid 5 cycles after ren with 0xdeadbeef.
  - RVALID is held until RREADY; RDATA = 0xdeadbeef.
- Ordering and backpressure:
  - W sent 3 cycles before AW → one LB write with correct fields.
  - BREADY held low → BVALID stays high and no new AWREADY until BREADY.

Source files
------------

// File: rtl/axil_lb_pkg.sv
// Shared types for the AXI4-Lite to local-bus bridge: FSM state encodings and
// the fixed AXI response code.
package axil_lb_pkg;

    typedef enum logic [1:0] {
        W_IDLE,
        W_LB,
        W_RESP
    } w_state_e;

    typedef enum logic [1:0] {
        R_IDLE,
        R_REQ,
        R_WAIT,
        R_RESP
    } r_state_e;

    localparam logic [1:0] RESP_OKAY = 2'b00;

endpackage

// File: rtl/axil_lb_bridge.sv
// AXI4-Lite slave to local-bus master bridge. Each AXI write or read becomes a
// single LB write or read; the write and read FSMs run independently.
module axil_lb_bridge
    import axil_lb_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32,
    parameter int STRB_W = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] AXIL_AWADDR,
    input  logic [2:0]        AXIL_AWPROT,
    input  logic              AXIL_AWVALID,
    output logic              AXIL_AWREADY,
    input  logic [DATA_W-1:0] AXIL_WDATA,
    input  logic [STRB_W-1:0] AXIL_WSTRB,
    input  logic              AXIL_WVALID,
    output logic              AXIL_WREADY,
    output logic [1:0]        AXIL_BRESP,
    output logic              AXIL_BVALID,
    input  logic              AXIL_BREADY,
    input  logic [ADDR_W-1:0] AXIL_ARADDR,
    input  logic [2:0]        AXIL_ARPROT,
    input  logic              AXIL_ARVALID,
    output logic              AXIL_ARREADY,
    output logic [DATA_W-1:0] AXIL_RDATA,
    output logic [1:0]        AXIL_RRESP,
    output logic              AXIL_RVALID,
    input  logic              AXIL_RREADY,
    input  logic              wready,
    output logic [ADDR_W-1:0] waddr,
    output logic [DATA_W-1:0] wdata,
    output logic [STRB_W-1:0] wstrb,
    output logic              wen,
    input  logic [DATA_W-1:0] rdata,
    input  logic              rvalid,
    output logic [ADDR_W-1:0] raddr,
    output logic              ren
);

    // Protection bits carry no meaning for a CSR map.
    logic unused_prot;
    assign unused_prot = ^{AXIL_AWPROT, AXIL_ARPROT};

    // ---------------- write path ----------------
    w_state_e          w_state_q, w_state_d;
    logic              aw_got_q, aw_got_d;
    logic              w_got_q, w_got_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0] wstrb_q, wstrb_d;
    logic              axil_awready_q, axil_awready_d;
    logic              axil_wready_q, axil_wready_d;
    logic              wen_q, wen_d;
    logic              axil_bvalid_q, axil_bvalid_d;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_d = w_state_q;
        aw_got_d  = aw_got_q;
        w_got_d   = w_got_q;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        case (w_state_q)
            W_IDLE: begin
                if (AXIL_AWVALID && axil_awready_q) begin
                    waddr_d  = AXIL_AWADDR;
                    aw_got_d = 1'b1;
                end
                if (AXIL_WVALID && axil_wready_q) begin
                    wdata_d = AXIL_WDATA;
                    wstrb_d = AXIL_WSTRB;
                    w_got_d = 1'b1;
                end
                if (aw_got_d && w_got_d) w_state_d = W_LB;
            end
            W_LB: begin
                if (wready) begin
                    w_state_d = W_RESP;
                    aw_got_d  = 1'b0;
                    w_got_d   = 1'b0;
                end
            end
            W_RESP: if (AXIL_BREADY) w_state_d = W_IDLE;
            default: w_state_d = W_IDLE;
        endcase
        // Handshake outputs are registered from the next state so they read 0 in reset.
        axil_awready_d = (w_state_d == W_IDLE) && !aw_got_d;
        axil_wready_d  = (w_state_d == W_IDLE) && !w_got_d;
        wen_d          = (w_state_d == W_LB);
        axil_bvalid_d  = (w_state_d == W_RESP);
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state_q      <= W_IDLE;
            aw_got_q       <= 1'b0;
            w_got_q        <= 1'b0;
            waddr_q        <= '0;
            wdata_q        <= '0;
            wstrb_q        <= '0;
            axil_awready_q <= 1'b0;
            axil_wready_q  <= 1'b0;
            wen_q          <= 1'b0;
            axil_bvalid_q  <= 1'b0;
        end else begin
            w_state_q      <= w_state_d;
            aw_got_q       <= aw_got_d;
            w_got_q        <= w_got_d;
            waddr_q        <= waddr_d;
            wdata_q        <= wdata_d;
            wstrb_q        <= wstrb_d;
            axil_awready_q <= axil_awready_d;
            axil_wready_q  <= axil_wready_d;
            wen_q          <= wen_d;
            axil_bvalid_q  <= axil_bvalid_d;
        end
    end

    // ---------------- read path ----------------
    r_state_e          r_state_q, r_state_d;
    logic [ADDR_W-1:0] raddr_q, raddr_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              axil_arready_q, axil_arready_d;
    logic              ren_q, ren_d;
    logic              axil_rvalid_q, axil_rvalid_d;

    always_comb begin
        r_state_d = r_state_q;
        raddr_d   = raddr_q;
        rdata_d   = rdata_q;
        case (r_state_q)
            R_IDLE: begin
                if (AXIL_ARVALID && axil_arready_q) begin
                    raddr_d   = AXIL_ARADDR;
                    r_state_d = R_REQ;
                end
            end
            // A zero-latency LB slave may answer while ren is still high.
            R_REQ: begin
                if (rvalid) begin
                    rdata_d   = rdata;
                    r_state_d = R_RESP;
                end else begin
                    r_state_d = R_WAIT;
                end
            end
            R_WAIT: begin
                if (rvalid) begin
                    rdata_d   = rdata;
                    r_state_d = R_RESP;
                end
            end
            R_RESP: if (AXIL_RREADY) r_state_d = R_IDLE;
            default: r_state_d = R_IDLE;
        endcase
        axil_arready_d = (r_state_d == R_IDLE);
        ren_d          = (r_state_d == R_REQ);
        axil_rvalid_d  = (r_state_d == R_RESP);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q      <= R_IDLE;
            raddr_q        <= '0;
            rdata_q        <= '0;
            axil_arready_q <= 1'b0;
            ren_q          <= 1'b0;
            axil_rvalid_q  <= 1'b0;
        end else begin
            r_state_q      <= r_state_d;
            raddr_q        <= raddr_d;
            rdata_q        <= rdata_d;
            axil_arready_q <= axil_arready_d;
            ren_q          <= ren_d;
            axil_rvalid_q  <= axil_rvalid_d;
        end
    end

    assign AXIL_AWREADY = axil_awready_q;
    assign AXIL_WREADY  = axil_wready_q;
    assign AXIL_BVALID  = axil_bvalid_q;
    assign AXIL_BRESP   = RESP_OKAY;
    assign waddr        = waddr_q;
    assign wdata        = wdata_q;
    assign wstrb        = wstrb_q;
    assign wen          = wen_q;
    assign AXIL_ARREADY = axil_arready_q;
    assign AXIL_RVALID  = axil_rvalid_q;
    assign AXIL_RDATA   = rdata_q;
    assign AXIL_RRESP   = RESP_OKAY;
    assign raddr        = raddr_q;
    assign ren          = ren_q;

endmodule

// File: tb/tb_axil_lb_bridge.sv
// Self-checking bench for axil_lb_bridge: randomized AXI-Lite traffic, an LB
// register-block model, and a scoreboard fed by stimulus and drained by monitors.
`timescale 1ns/1ps
module tb_axil_lb_bridge;
    import axil_lb_pkg::*;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 32;
    localparam int STRB_W = 4;
    localparam int BUDGET = 200;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [ADDR_W-1:0] AXIL_AWADDR = '0;
    logic [2:0]        AXIL_AWPROT = '0;
    logic              AXIL_AWVALID = 1'b0;
    logic              AXIL_AWREADY;
    logic [DATA_W-1:0] AXIL_WDATA = '0;
    logic [STRB_W-1:0] AXIL_WSTRB = '0;
    logic              AXIL_WVALID = 1'b0;
    logic              AXIL_WREADY;
    logic [1:0]        AXIL_BRESP;
    logic              AXIL_BVALID;
    logic              AXIL_BREADY = 1'b0;
    logic [ADDR_W-1:0] AXIL_ARADDR = '0;
    logic [2:0]        AXIL_ARPROT = '0;
    logic              AXIL_ARVALID = 1'b0;
    logic              AXIL_ARREADY;
    logic [DATA_W-1:0] AXIL_RDATA;
    logic [1:0]        AXIL_RRESP;
    logic              AXIL_RVALID;
    logic              AXIL_RREADY = 1'b0;
    logic              wready = 1'b0;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    logic              wen;
    logic [DATA_W-1:0] rdata = '0;
    logic              rvalid = 1'b0;
    logic [ADDR_W-1:0] raddr;
    logic              ren;

    axil_lb_bridge #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STRB_W(STRB_W)) dut (
        .clk(clk), .rst(rst),
        .AXIL_AWADDR(AXIL_AWADDR), .AXIL_AWPROT(AXIL_AWPROT),
        .AXIL_AWVALID(AXIL_AWVALID), .AXIL_AWREADY(AXIL_AWREADY),
        .AXIL_WDATA(AXIL_WDATA), .AXIL_WSTRB(AXIL_WSTRB),
        .AXIL_WVALID(AXIL_WVALID), .AXIL_WREADY(AXIL_WREADY),
        .AXIL_BRESP(AXIL_BRESP), .AXIL_BVALID(AXIL_BVALID), .AXIL_BREADY(AXIL_BREADY),
        .AXIL_ARADDR(AXIL_ARADDR), .AXIL_ARPROT(AXIL_ARPROT),
        .AXIL_ARVALID(AXIL_ARVALID), .AXIL_ARREADY(AXIL_ARREADY),
        .AXIL_RDATA(AXIL_RDATA), .AXIL_RRESP(AXIL_RRESP),
        .AXIL_RVALID(AXIL_RVALID), .AXIL_RREADY(AXIL_RREADY),
        .wready(wready), .waddr(waddr), .wdata(wdata), .wstrb(wstrb), .wen(wen),
        .rdata(rdata), .rvalid(rvalid), .raddr(raddr), .ren(ren)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [STRB_W-1:0] strb;
    } lbw_t;

    lbw_t              exp_lbw[$];
    logic [1:0]        exp_b[$];
    logic [ADDR_W-1:0] exp_raddr[$];
    logic [DATA_W-1:0] exp_rdata[$];
    logic [DATA_W-1:0] ref_mem[logic [ADDR_W-1:0]];
    logic [DATA_W-1:0] lb_mem[logic [ADDR_W-1:0]];

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_event(input string name, input string got, input string want);
        n_cmp++;
        n_err++;
        $display("FAIL %s: got %s, expected %s (t=%0t)", name, got, want, $time);
    endtask

    // Byte-lane merge: a strobed write replaces only the enabled bytes.
    function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old,
                                                input logic [DATA_W-1:0] d,
                                                input logic [STRB_W-1:0] s);
        logic [DATA_W-1:0] r;
        r = old;
        for (int i = 0; i < STRB_W; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    function automatic logic [DATA_W-1:0] ref_read(input logic [ADDR_W-1:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : '0;
    endfunction

    function automatic logic [DATA_W-1:0] lb_read(input logic [ADDR_W-1:0] a);
        return lb_mem.exists(a) ? lb_mem[a] : '0;
    endfunction

    // ---------------- LB slave model ----------------
    int  lb_wwait = 0;
    int  wcnt = 0;
    always @(posedge clk) begin
        #1;
        if (wen) begin
            if (wcnt >= lb_wwait) wready = 1'b1;
            else begin
                wready = 1'b0;
                wcnt++;
            end
        end else begin
            wready = ($urandom_range(0, 3) == 0);
            wcnt = 0;
        end
    end

    int                lb_rwait = 0;
    int                rcnt = 0;
    bit                rbusy = 1'b0;
    bit                rd_pending = 1'b0;
    logic [ADDR_W-1:0] rkey = '0;
    always @(posedge clk) begin
        #1;
        if (rbusy) begin
            if (rcnt == 0) begin
                rvalid = 1'b1;
                rdata  = lb_read(rkey);
                rbusy  = 1'b0;
            end else begin
                rvalid = 1'b0;
                rdata  = $urandom;
                rcnt--;
            end
        end else if (ren) begin
            rkey = raddr;
            if (lb_rwait == 0) begin
                rvalid = 1'b1;
                rdata  = lb_read(raddr);
            end else begin
                rbusy  = 1'b1;
                rcnt   = lb_rwait - 1;
                rvalid = 1'b0;
                rdata  = $urandom;
            end
        end else begin
            // Stray rvalid while no read is in flight must be ignored.
            rvalid = !rd_pending && ($urandom_range(0, 3) == 0);
            rdata  = $urandom;
        end
    end

    // ---------------- monitors ----------------
    lbw_t              last_w;
    logic [ADDR_W-1:0] last_raddr = '0;
    bit prev_wen_wait = 1'b0, prev_ren = 1'b0, prev_bv_stall = 1'b0, prev_rv_stall = 1'b0;

    always @(negedge clk) begin
        lbw_t e;
        if (rst) begin
            prev_wen_wait = 1'b0;
            prev_ren      = 1'b0;
            prev_bv_stall = 1'b0;
            prev_rv_stall = 1'b0;
        end else begin
            if (prev_wen_wait) check("wen_hold", 64'(wen), 64'd1);
            if (wen) check("bvalid_during_lb", 64'(AXIL_BVALID), 64'd0);
            if (wen && wready) begin
                if (exp_lbw.size() == 0) fail_event("lb_write", "unexpected LB write", "none");
                else begin
                    e = exp_lbw.pop_front();
                    check("lb_waddr", 64'(waddr), 64'(e.addr));
                    check("lb_wdata", 64'(wdata), 64'(e.data));
                    check("lb_wstrb", 64'(wstrb), 64'(e.strb));
                    lb_mem[waddr] = merge(lb_read(waddr), wdata, wstrb);
                    last_w = e;
                end
            end
            prev_wen_wait = wen && !wready;

            if (prev_bv_stall) check("bvalid_hold", 64'(AXIL_BVALID), 64'd1);
            if (AXIL_BVALID) begin
                check("awready_in_resp", 64'(AXIL_AWREADY), 64'd0);
                check("wready_in_resp", 64'(AXIL_WREADY), 64'd0);
            end
            if (AXIL_BVALID && AXIL_BREADY) begin
                if (exp_b.size() == 0) fail_event("b_resp", "unexpected BVALID", "none");
                else begin
                    check("bresp", 64'(AXIL_BRESP), 64'(exp_b.pop_front()));
                    check("waddr_stable", 64'(waddr), 64'(last_w.addr));
                    check("wdata_stable", 64'(wdata), 64'(last_w.data));
                    check("wstrb_stable", 64'(wstrb), 64'(last_w.strb));
                end
            end
            prev_bv_stall = AXIL_BVALID && !AXIL_BREADY;

            if (ren) begin
                check("ren_one_cycle", 64'(prev_ren), 64'd0);
                if (exp_raddr.size() == 0) fail_event("lb_read", "unexpected ren", "none");
                else begin
                    last_raddr = exp_raddr.pop_front();
                    check("lb_raddr", 64'(raddr), 64'(last_raddr));
                end
            end
            prev_ren = ren;

            if (prev_rv_stall) check("rvalid_hold", 64'(AXIL_RVALID), 64'd1);
            if (AXIL_RVALID) check("arready_in_resp", 64'(AXIL_ARREADY), 64'd0);
            if (AXIL_RVALID && AXIL_RREADY) begin
                if (exp_rdata.size() == 0) fail_event("r_resp", "unexpected RVALID", "none");
                else begin
                    check("rdata", 64'(AXIL_RDATA), 64'(exp_rdata.pop_front()));
                    check("rresp", 64'(AXIL_RRESP), 64'(RESP_OKAY));
                    check("raddr_stable", 64'(raddr), 64'(last_raddr));
                end
            end
            prev_rv_stall = AXIL_RVALID && !AXIL_RREADY;
        end
    end

    // ---------------- AXI master tasks ----------------
    task automatic aw_send(input logic [ADDR_W-1:0] a, input int dly);
        int n;
        @(posedge clk); #1;
        repeat (dly) begin @(posedge clk); #1; end
        AXIL_AWADDR  = a;
        AXIL_AWPROT  = 3'($urandom);
        AXIL_AWVALID = 1'b1;
        n = 0;
        @(negedge clk);
        while (!AXIL_AWREADY && n < BUDGET) begin @(negedge clk); n++; end
        if (n >= BUDGET) fail_event("aw_handshake", "no AWREADY", "AWREADY within budget");
        @(posedge clk); #1;
        AXIL_AWVALID = 1'b0;
        AXIL_AWADDR  = 16'($urandom);
    endtask

    task automatic w_send(input logic [DATA_W-1:0] d, input logic [STRB_W-1:0] s, input int dly);
        int n;
        @(posedge clk); #1;
        repeat (dly) begin @(posedge clk); #1; end
        AXIL_WDATA  = d;
        AXIL_WSTRB  = s;
        AXIL_WVALID = 1'b1;
        n = 0;
        @(negedge clk);
        while (!AXIL_WREADY && n < BUDGET) begin @(negedge clk); n++; end
        if (n >= BUDGET) fail_event("w_handshake", "no WREADY", "WREADY within budget");
        @(posedge clk); #1;
        AXIL_WVALID = 1'b0;
        AXIL_WDATA  = $urandom;
        AXIL_WSTRB  = 4'($urandom);
    endtask

    task automatic axi_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                             input logic [STRB_W-1:0] s, input int aw_dly, input int w_dly,
                             input int wwait, input int b_dly);
        int n;
        lb_wwait = wwait;
        exp_lbw.push_back('{addr: a, data: d, strb: s});
        exp_b.push_back(RESP_OKAY);
        ref_mem[a] = merge(ref_read(a), d, s);
        fork
            aw_send(a, aw_dly);
            w_send(d, s, w_dly);
        join
        n = 0;
        @(negedge clk);
        while (!AXIL_BVALID && n < BUDGET) begin @(negedge clk); n++; end
        if (n >= BUDGET) fail_event("b_wait", "no BVALID", "BVALID within budget");
        repeat (b_dly + 1) @(posedge clk);
        #1 AXIL_BREADY = 1'b1;
        @(posedge clk);
        #1 AXIL_BREADY = 1'b0;
    endtask

    task automatic axi_read(input logic [ADDR_W-1:0] a, input int rwait, input int r_dly);
        int n;
        @(posedge clk); #1;
        lb_rwait   = rwait;
        rd_pending = 1'b1;
        exp_raddr.push_back(a);
        exp_rdata.push_back(ref_read(a));
        AXIL_ARADDR  = a;
        AXIL_ARPROT  = 3'($urandom);
        AXIL_ARVALID = 1'b1;
        n = 0;
        @(negedge clk);
        while (!AXIL_ARREADY && n < BUDGET) begin @(negedge clk); n++; end
        if (n >= BUDGET) fail_event("ar_handshake", "no ARREADY", "ARREADY within budget");
        @(posedge clk); #1;
        AXIL_ARVALID = 1'b0;
        AXIL_ARADDR  = 16'($urandom);
        n = 0;
        @(negedge clk);
        while (!AXIL_RVALID && n < BUDGET) begin @(negedge clk); n++; end
        if (n >= BUDGET) fail_event("r_wait", "no RVALID", "RVALID within budget");
        repeat (r_dly + 1) @(posedge clk);
        #1 AXIL_RREADY = 1'b1;
        @(posedge clk);
        #1 AXIL_RREADY = 1'b0;
        rd_pending = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_awready"}, 64'(AXIL_AWREADY), 64'd0);
        check({tag, "_wready"},  64'(AXIL_WREADY),  64'd0);
        check({tag, "_arready"}, 64'(AXIL_ARREADY), 64'd0);
        check({tag, "_bvalid"},  64'(AXIL_BVALID),  64'd0);
        check({tag, "_rvalid"},  64'(AXIL_RVALID),  64'd0);
        check({tag, "_wen"},     64'(wen),          64'd0);
        check({tag, "_ren"},     64'(ren),          64'd0);
        check({tag, "_waddr"},   64'(waddr),        64'd0);
        check({tag, "_wdata"},   64'(wdata),        64'd0);
        check({tag, "_wstrb"},   64'(wstrb),        64'd0);
        check({tag, "_raddr"},   64'(raddr),        64'd0);
        check({tag, "_rdata"},   64'(AXIL_RDATA),   64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of test, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        int                n;
        int                op;
        logic [ADDR_W-1:0] wa, ra;

        ref_mem[16'h014] = 32'hc0debabe;
        lb_mem[16'h014]  = 32'hc0debabe;
        ref_mem[16'h008] = 32'hdeadbeef;
        lb_mem[16'h008]  = 32'hdeadbeef;

        #2 rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        check("reset_bresp", 64'(AXIL_BRESP), 64'd0);
        check("reset_rresp", 64'(AXIL_RRESP), 64'd0);
        @(posedge clk); #1 rst = 1'b0;

        axi_write(16'h004, 32'hdeadbeef, 4'hf, 0, 0, 0, 0);
        axi_write(16'h00c, 32'hcafebabe, 4'b0110, 0, 0, 0, 0);
        axi_write(16'h010, 32'h0acce55, 4'hf, 0, 0, 5, 0);
        axi_read(16'h014, 1, 0);
        axi_read(16'h008, 5, 3);
        axi_write(16'h018, 32'h12345678, 4'hf, 3, 0, 0, 0);
        axi_write(16'h01c, 32'h87654321, 4'hf, 0, 0, 0, 6);
        axi_read(16'h00c, 0, 0);
        axi_read(16'h010, 2, 1);

        for (int i = 0; i < 40; i++) begin
            op = $urandom_range(0, 2);
            wa = 16'({$urandom_range(0, 63), 2'b00});
            ra = (wa + 16'(4 * $urandom_range(1, 63))) & 16'h00fc;
            case (op)
                0: axi_write(wa, $urandom, 4'($urandom), $urandom_range(0, 3),
                             $urandom_range(0, 3), $urandom_range(0, 4), $urandom_range(0, 3));
                1: axi_read(ra, $urandom_range(0, 4), $urandom_range(0, 3));
                default: fork
                    axi_write(wa, $urandom, 4'($urandom), $urandom_range(0, 3),
                              $urandom_range(0, 3), $urandom_range(0, 4), $urandom_range(0, 3));
                    axi_read(ra, $urandom_range(0, 4), $urandom_range(0, 3));
                join
            endcase
        end

        // Abort a write mid-flight: wen is up and the LB slave is stalling.
        lb_wwait = 1000;
        fork
            aw_send(16'h030, 0);
            w_send(32'h5a5a5a5a, 4'hf, 0);
        join
        n = 0;
        @(negedge clk);
        while (!wen && n < BUDGET) begin @(negedge clk); n++; end
        if (n >= BUDGET) fail_event("abort_wen", "no wen", "wen within budget");
        @(posedge clk);
        #3 rst = 1'b1;
        #1 check_all_zero("abort");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        lb_wwait = 0;
        repeat (5) begin
            @(negedge clk);
            check("post_abort_wen", 64'(wen), 64'd0);
            check("post_abort_bvalid", 64'(AXIL_BVALID), 64'd0);
        end

        axi_write(16'h020, 32'hfeedf00d, 4'b1001, 1, 0, 2, 1);
        axi_read(16'h020, 3, 0);

        repeat (5) @(posedge clk);
        check("pending_lb_writes", 64'(exp_lbw.size()), 64'd0);
        check("pending_b", 64'(exp_b.size()), 64'd0);
        check("pending_lb_reads", 64'(exp_raddr.size()), 64'd0);
        check("pending_r", 64'(exp_rdata.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
